// File: rtl/rr_pipe_arbiter_if.sv
// Request/grant bundle between M requesters and the shared arbiter pipeline stage.
// Arbiter side uses the slave modport, the requesters/downstream use master.
interface rr_pipe_arbiter_if #(
    parameter int unsigned N = 16,
    parameter int unsigned M = 4
);
    logic                   EN;
    logic [M-1:0]           R_IN;
    logic [M-1:0]           LOCK_IN;
    logic [M*N-1:0]         D_IN;
    logic [M-1:0]           ACK;
    logic                   R_OUT;
    logic [N-1:0]           D_OUT;
    logic [$clog2(M)-1:0]   SRC_OUT;

    modport slave (
        input  EN, R_IN, LOCK_IN, D_IN,
        output ACK, R_OUT, D_OUT, SRC_OUT
    );

    modport master (
        output EN, R_IN, LOCK_IN, D_IN,
        input  ACK, R_OUT, D_OUT, SRC_OUT
    );
endinterface

// File: rtl/rr_pipe_arbiter.sv
// Round-robin arbiter feeding one registered data stage, with bounded lock bursts.
// Latency: ACK is combinational; D_OUT/R_OUT/SRC_OUT valid one cycle after the grant.
// Backpressure: EN=0 stalls everything (no ACK, all state held); requesters hold R_IN until ACK.
module rr_pipe_arbiter #(
    parameter int unsigned N         = 16,
    parameter int unsigned M         = 4,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic CLK,
    input  logic RST,
    rr_pipe_arbiter_if.slave bus
);
    localparam int unsigned SW = $clog2(M);
    localparam int unsigned CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_BURST);

    typedef enum logic {ARB, BURST} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   ptr_q, ptr_d;
    logic [SW-1:0]   own_q, own_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            r_out_q, r_out_d;
    logic [N-1:0]    d_out_q, d_out_d;
    logic [SW-1:0]   src_q, src_d;
    logic [SW-1:0]   start;
    logic [SW-1:0]   win;
    logic            found;
    logic [M-1:0]    ack;

    // (base + off) mod M without a divider; M need not be a power of two.
    function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= M) s = s - M;
        return s[SW-1:0];
    endfunction

    // A lapsed burst owner hands the search start to its successor, so no bubble.
    always_comb begin
        start = (state_q == BURST) ? wrap_add(own_q, 1) : ptr_q;
        found = 1'b0;
        win   = '0;
        for (int i = M - 1; i >= 0; i--) begin
            if (bus.R_IN[wrap_add(start, unsigned'(i))]) begin
                found = 1'b1;
                win   = wrap_add(start, unsigned'(i));
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        cnt_d   = cnt_q;
        r_out_d = r_out_q;
        d_out_d = d_out_q;
        src_d   = src_q;
        ack     = '0;
        if (bus.EN && !RST) begin
            r_out_d = 1'b0;
            if (state_q == BURST && bus.R_IN[own_q]) begin
                ack[own_q] = 1'b1;
                r_out_d    = 1'b1;
                d_out_d    = bus.D_IN[own_q*N +: N];
                src_d      = own_q;
                cnt_d      = cnt_q + CW'(1);
                if (!bus.LOCK_IN[own_q] || (cnt_q + CW'(1)) == MAX_C) begin
                    state_d = ARB;
                    ptr_d   = wrap_add(own_q, 1);
                    cnt_d   = '0;
                end
            end else if (found) begin
                ack[win] = 1'b1;
                r_out_d  = 1'b1;
                d_out_d  = bus.D_IN[win*N +: N];
                src_d    = win;
                cnt_d    = CW'(1);
                if (bus.LOCK_IN[win] && MAX_BURST > 1) begin
                    state_d = BURST;
                    own_d   = win;
                end else begin
                    state_d = ARB;
                    ptr_d   = wrap_add(win, 1);
                end
            end else begin
                state_d = ARB;
                ptr_d   = start;
                if (state_q == BURST) cnt_d = '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ARB;
            ptr_q   <= '0;
            own_q   <= '0;
            cnt_q   <= '0;
            r_out_q <= 1'b0;
            d_out_q <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            cnt_q   <= cnt_d;
            r_out_q <= r_out_d;
            d_out_q <= d_out_d;
            src_q   <= src_d;
        end
    end

    assign bus.ACK     = ack;
    assign bus.R_OUT   = r_out_q;
    assign bus.D_OUT   = d_out_q;
    assign bus.SRC_OUT = src_q;
endmodule
